sdram_memtest: RTL and testbench
================================

Name: sdram_memtest

Overview:
- Parametrised SDRAM memory tester that sweeps a configurable address window:
  - write phase writes a pattern to every word in the window;
  - a programmable retention dwell follows, exercising controller refresh;
  - read phase reads every word back and compares it with the expected pattern.
- Sits between the board top level (switches, LEDs, hex display) and the SDRAM controller's user read/write port.
- Reports pass/fail, error count and first failing address/data.
- Restartable without reset.

Parameters:
- ADDR_W, 25: controller address width (2 bank, 13 row, 10 col).
- DATA_W, 32: controller data width.
- BASE_ADDR, 25'h0000100: first word address tested.
- NUM_WORDS, 1024: words in window, must be 1 to 2^ADDR_W - BASE_ADDR.
- DWELL_CYCLES, 300: idle Clk cycles between last write ack and first read request, must be 1 or more.
- PATTERN, 32'hDEADBEEF: seed pattern for all modes.
- ERR_W, 16: error counter width.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  pulse or level; sampled only in IDLE.
- Mode  in  2  pattern mode, latched when Start is accepted.
- INIT_DONE  in  1  controller initialisation complete.
- RW_ACK  in  1  controller accepted or completed current request; one-cycle pulse.
- DATA_READ  in  DATA_W  read data, valid in the RW_ACK cycle of a read.
- DATA_ADDR  out  ADDR_W  request address.
- DATA_WRITE  out  DATA_W  write data.
- RW_READ  out  1  read request.
- RW_WRITE  out  1  write request.
- BUSY  out  1  test in progress.
- PASS  out  1  test finished, zero errors.
- FAIL  out  1  test finished, one or more errors.
- ERR_COUNT  out  ERR_W  mismatches, saturating.
- FIRST_ERR_ADDR  out  ADDR_W  address of first mismatch.
- FIRST_ERR_DATA  out  DATA_W  data read at first mismatch.
- INIT_SEEN  out  1  INIT_DONE has been observed since reset (LED).

Behaviour:
- Reset (async assert, sync-released by top level):
  - state IDLE;
  - all outputs 0, including DATA_ADDR and DATA_WRITE; nothing is driven Z;
  - index, ERR_COUNT, FIRST_ERR_* cleared.
- Expected data for word index i (0..NUM_WORDS-1), addr = BASE_ADDR + i:
  - Mode 0: PATTERN.
  - Mode 1: PATTERN XOR zero-extended addr.
  - Mode 2: 1 << (i mod DATA_W).
  - Mode 3: PATTERN if i even, else ~PATTERN.
- States:
  - IDLE: INIT_SEEN is sticky-set on INIT_DONE. If INIT_SEEN and Start are both high: latch Mode, clear index, ERR_COUNT and FIRST_ERR_*, clear PASS/FAIL, go to WRITE. Start before INIT_DONE is ignored.
  - WRITE: RW_WRITE=1, DATA_ADDR=addr, DATA_WRITE=expected(i), held stable until RW_ACK. On ack: if i = NUM_WORDS-1, clear index and go to DWELL; else i++ and go to WRITE_GAP.
  - WRITE_GAP: one cycle with RW_WRITE=0, so requests are never back-to-back; then WRITE.
  - DWELL: dwell timer started on entry; no requests. Leave for READ after exactly DWELL_CYCLES cycles.
  - READ: RW_READ=1, DATA_ADDR=addr. On RW_ACK, capture DATA_READ into a register and go to CHECK.
  - CHECK: one cycle; compare the captured word with expected(i).
    - On mismatch: ERR_COUNT++ (saturates at all-ones). If ERR_COUNT was 0, load FIRST_ERR_ADDR/DATA.
    - Then: if last index, go to DONE; else i++ and go to READ.
  - DONE: PASS = (ERR_COUNT==0), FAIL = !PASS, held. Start returns to IDLE-accept behaviour: a new test begins on the next Start, taken directly from DONE.
- BUSY = 1 in every state except IDLE and DONE.
- RW_READ and RW_WRITE are never asserted simultaneously.
- An RW_ACK arriving outside WRITE/READ is ignored.
- Arithmetic:
  - index is clog2(NUM_WORDS) bits, or 1 if NUM_WORDS=1.
  - addr is computed in ADDR_W bits with no wrap: the parameter range guarantees it fits.
- NUM_WORDS=1: one write, dwell, one read, done.
- Reset mid-operation: immediate return to IDLE. Request lines drop asynchronously.
- Start held high continuously: the test restarts on the cycle after DONE is reached; PASS/FAIL is visible for one cycle.

Decomposition:
- Package sdram_memtest_pkg:
  - state enum;
  - mode enum (MODE_CONST, MODE_ADDR, MODE_WALK1, MODE_CHECKER);
  - function expected_data(mode, index, addr, pattern).
- Sub-module memtest_dwell_timer:
  - parameter CYCLES; ports Clk, Reset_n, Start, Done;
  - Start loads the count, Done pulses when it reaches 0.

Test Plan:
- Ideal SDRAM model (ack 3 cycles after request), NUM_WORDS=8, Mode 0, Start after INIT_DONE → 8 writes of DEADBEEF to 0x100..0x107, then a 300-cycle gap, 8 reads, PASS=1, ERR_COUNT=0.
- Model corrupts the word at 0x103 (bit 0 flipped), Mode 1 → FAIL=1, ERR_COUNT=1, FIRST_ERR_ADDR=0x103, FIRST_ERR_DATA=(DEADBEEF^0x103)^1.
- Model returns 0 for all reads, NUM_WORDS=8, Mode 2 → ERR_COUNT=8, FIRST_ERR_ADDR=0x100, FIRST_ERR_DATA=0.
- Start asserted before INIT_DONE → no requests issued and BUSY=0. After INIT_DONE rises and Start pulses → test runs.
- Reset_n pulsed low during READ of index 4 → RW_READ=0 and BUSY=0 immediately. A restart completes with PASS.
- Mode 3 back-to-back runs via Start in DONE, with ack latency varied 1-10 cycles → every request held until ack, at least one idle cycle between writes, PASS both runs.

Source files
------------

// File: rtl/sdram_memtest_pkg.sv
// Shared types and the pattern generator for the SDRAM window tester.
package sdram_memtest_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRITE_GAP,
    ST_DWELL,
    ST_READ,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_CONST,
    MODE_ADDR,
    MODE_WALK1,
    MODE_CHECKER
  } mode_e;

  // Caller truncates the result to its own data width.
  function automatic logic [MAX_W-1:0] expected_data(
    input mode_e             mode,
    input logic [31:0]       index,
    input logic [MAX_W-1:0]  addr,
    input logic [MAX_W-1:0]  pattern,
    input int unsigned       data_w
  );
    logic [MAX_W-1:0] v;
    case (mode)
      MODE_CONST: v = pattern;
      MODE_ADDR:  v = pattern ^ addr;
      MODE_WALK1: v = MAX_W'(1) << (index % data_w);
      default:    v = index[0] ? ~pattern : pattern;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sdram_memtest_dwell_timer.sv
// Retention dwell countdown: Start loads the count, Done is high for the
// single cycle in which the count sits at zero.
module memtest_dwell_timer #(
  parameter int CYCLES = 300
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Start,
  output logic Done
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (Start) begin
      r_cnt <= CNT_W'(CYCLES - 1);
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign Done = r_run && (r_cnt == '0);

endmodule

// File: rtl/sdram_memtest.sv
// Write / dwell / read-back tester for one SDRAM address window, driving the
// controller's single-request user port and reporting pass/fail details.
module sdram_memtest
  import sdram_memtest_pkg::*;
#(
  parameter int                ADDR_W       = 25,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 25'h0000100,
  parameter int                NUM_WORDS    = 1024,
  parameter int                DWELL_CYCLES = 300,
  parameter logic [DATA_W-1:0] PATTERN      = 32'hDEADBEEF,
  parameter int                ERR_W        = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [1:0]        Mode,
  input  logic              INIT_DONE,
  input  logic              RW_ACK,
  input  logic [DATA_W-1:0] DATA_READ,
  output logic [ADDR_W-1:0] DATA_ADDR,
  output logic [DATA_W-1:0] DATA_WRITE,
  output logic              RW_READ,
  output logic              RW_WRITE,
  output logic              BUSY,
  output logic              PASS,
  output logic              FAIL,
  output logic [ERR_W-1:0]  ERR_COUNT,
  output logic [ADDR_W-1:0] FIRST_ERR_ADDR,
  output logic [DATA_W-1:0] FIRST_ERR_DATA,
  output logic              INIT_SEEN
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_e            r_state, w_next;
  mode_e             r_mode;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_rdata;
  logic [ERR_W-1:0]  r_err;
  logic [ADDR_W-1:0] r_ferr_addr;
  logic [DATA_W-1:0] r_ferr_data;
  logic              r_pass, r_fail, r_init_seen;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_exp;
  logic              w_last, w_go, w_mis, w_dwell_start, w_dwell_done;

  assign w_addr = BASE_ADDR + ADDR_W'(r_idx);
  assign w_exp  = DATA_W'(expected_data(r_mode, 32'(r_idx), MAX_W'(w_addr),
                                        MAX_W'(PATTERN), DATA_W));
  assign w_last = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign w_mis  = (r_rdata != w_exp);
  assign w_go   = r_init_seen && Start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_dwell_start = (r_state == ST_WRITE) && RW_ACK && w_last;

  memtest_dwell_timer #(.CYCLES(DWELL_CYCLES)) u_dwell (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (w_dwell_start),
    .Done    (w_dwell_done)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Request lines decode straight from the state register so an async reset
  // drops them without waiting for a clock.
  always_comb begin
    w_next     = r_state;
    RW_WRITE   = 1'b0;
    RW_READ    = 1'b0;
    DATA_ADDR  = '0;
    DATA_WRITE = '0;
    BUSY       = 1'b1;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        BUSY = 1'b0;
        if (w_go) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        RW_WRITE   = 1'b1;
        DATA_ADDR  = w_addr;
        DATA_WRITE = w_exp;
        if (RW_ACK) w_next = w_last ? ST_DWELL : ST_WRITE_GAP;
      end
      ST_WRITE_GAP: w_next = ST_WRITE;
      ST_DWELL:     if (w_dwell_done) w_next = ST_READ;
      ST_READ: begin
        RW_READ   = 1'b1;
        DATA_ADDR = w_addr;
        if (RW_ACK) w_next = ST_CHECK;
      end
      ST_CHECK:     w_next = w_last ? ST_DONE : ST_READ;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mode      <= MODE_CONST;
      r_idx       <= '0;
      r_rdata     <= '0;
      r_err       <= '0;
      r_ferr_addr <= '0;
      r_ferr_data <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_init_seen <= 1'b0;
    end else begin
      if (INIT_DONE) r_init_seen <= 1'b1;
      case (r_state)
        ST_IDLE, ST_DONE: if (w_go) begin
          r_mode      <= mode_e'(Mode);
          r_idx       <= '0;
          r_err       <= '0;
          r_ferr_addr <= '0;
          r_ferr_data <= '0;
          r_pass      <= 1'b0;
          r_fail      <= 1'b0;
        end
        ST_WRITE: if (RW_ACK) r_idx <= w_last ? '0 : r_idx + 1'b1;
        ST_READ:  if (RW_ACK) r_rdata <= DATA_READ;
        ST_CHECK: begin
          if (w_mis) begin
            if (r_err != '1) r_err <= r_err + 1'b1;
            if (r_err == '0) begin
              r_ferr_addr <= w_addr;
              r_ferr_data <= r_rdata;
            end
          end
          // Verdict must include the mismatch being counted this cycle.
          if (w_last) begin
            r_pass <= !w_mis && (r_err == '0);
            r_fail <= w_mis || (r_err != '0);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign PASS           = r_pass;
  assign FAIL           = r_fail;
  assign ERR_COUNT      = r_err;
  assign FIRST_ERR_ADDR = r_ferr_addr;
  assign FIRST_ERR_DATA = r_ferr_data;
  assign INIT_SEEN      = r_init_seen;

endmodule

// File: tb/tb_sdram_memtest.sv
// Randomised-latency SDRAM model plus a behavioural reference of the tester.
module tb_sdram_memtest;

  localparam int          NW    = 8;
  localparam int          DWELL = 300;
  localparam int          BASE  = 'h100;
  localparam logic [31:0] PAT   = 32'hDEADBEEF;

  logic        Clk = 1'b0;
  logic        Reset_n, Start, INIT_DONE, RW_ACK;
  logic [1:0]  Mode;
  logic [31:0] DATA_READ, DATA_WRITE, FIRST_ERR_DATA;
  logic [24:0] DATA_ADDR, FIRST_ERR_ADDR;
  logic        RW_READ, RW_WRITE, BUSY, PASS, FAIL, INIT_SEEN;
  logic [15:0] ERR_COUNT;

  sdram_memtest #(.NUM_WORDS(NW), .DWELL_CYCLES(DWELL)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode),
    .INIT_DONE(INIT_DONE), .RW_ACK(RW_ACK), .DATA_READ(DATA_READ),
    .DATA_ADDR(DATA_ADDR), .DATA_WRITE(DATA_WRITE), .RW_READ(RW_READ),
    .RW_WRITE(RW_WRITE), .BUSY(BUSY), .PASS(PASS), .FAIL(FAIL),
    .ERR_COUNT(ERR_COUNT), .FIRST_ERR_ADDR(FIRST_ERR_ADDR),
    .FIRST_ERR_DATA(FIRST_ERR_DATA), .INIT_SEEN(INIT_SEEN)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Memory model state and fault injection settings.
  logic [31:0] mem [int];
  int          wcnt, viol, nreq, dwell_gap, wack_cyc;
  bit          dwell_pend;
  int          lat_lo = 3, lat_hi = 3;
  int          fmode = 0, f_addr = 0;
  logic [31:0] f_mask = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_exp(input int m, input int i);
    logic [31:0] a;
    a = 32'(BASE + i);
    case (m)
      0:       return PAT;
      1:       return PAT ^ a;
      2:       return 32'd1 << (i % 32);
      default: return (i % 2 == 0) ? PAT : ~PAT;
    endcase
  endfunction

  function automatic logic [31:0] rd_fault(input int a, input logic [31:0] v);
    case (fmode)
      1:       return (a == f_addr) ? (v ^ f_mask) : v;
      2:       return 32'd0;
      default: return v;
    endcase
  endfunction

  // SDRAM responder: acks after a random latency, flags unstable requests,
  // simultaneous read/write, and back-to-back requests without an idle cycle.
  initial begin
    bit          act, need_gap, rw;
    int          k, lat, ra;
    logic [31:0] rdat;
    act = 0; need_gap = 0; k = 0; lat = 0; ra = 0; rw = 0; rdat = '0;
    RW_ACK = 1'b0; DATA_READ = '0;
    forever begin
      @(negedge Clk);
      RW_ACK = 1'b0;
      if (!Reset_n) begin
        act = 0; need_gap = 0; dwell_pend = 0;
      end else if (!(RW_READ || RW_WRITE)) begin
        need_gap = 0;
      end else begin
        if (RW_READ && RW_WRITE) viol++;
        if (need_gap) viol++;
        need_gap = 0;
        if (!act) begin
          act = 1; k = 0; nreq++;
          ra = int'(DATA_ADDR); rdat = DATA_WRITE; rw = RW_WRITE;
          lat = $urandom_range(lat_hi, lat_lo);
          if (!rw && dwell_pend) begin
            dwell_gap  = cyc - wack_cyc;
            dwell_pend = 0;
          end
        end else if (int'(DATA_ADDR) != ra || RW_WRITE != rw || (rw && DATA_WRITE != rdat)) begin
          viol++;
        end
        k++;
        if (k >= lat) begin
          RW_ACK = 1'b1; act = 0; need_gap = 1;
          if (rw) begin
            mem[ra] = rdat; wcnt++; wack_cyc = cyc; dwell_pend = 1;
          end else begin
            DATA_READ = rd_fault(ra, mem.exists(ra) ? mem[ra] : 32'd0);
          end
        end
      end
    end
  end

  task automatic clear_log();
    mem.delete();
    wcnt = 0; viol = 0; dwell_gap = -1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(PASS || FAIL) && n < 6000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 6000) chk({tag, ".timeout"}, 1, 0);
  endtask

  // Reference outcome of a full run, from the pattern rules and the fault.
  task automatic check_result(input string tag, input int m);
    int          ne, bad, fa;
    logic [31:0] e, r, fd;
    ne = 0; bad = 0; fa = 0; fd = '0;
    for (int i = 0; i < NW; i++) begin
      e = ref_exp(m, i);
      r = rd_fault(BASE + i, e);
      if (r != e) begin
        if (ne == 0) begin fa = BASE + i; fd = r; end
        ne++;
      end
      if (!mem.exists(BASE + i) || mem[BASE + i] != e) bad++;
    end
    chk({tag, ".pass"},  PASS, 64'(ne == 0));
    chk({tag, ".fail"},  FAIL, 64'(ne != 0));
    chk({tag, ".errs"},  ERR_COUNT, 64'(ne));
    chk({tag, ".faddr"}, FIRST_ERR_ADDR, 64'(fa));
    chk({tag, ".fdata"}, FIRST_ERR_DATA, 64'(fd));
    chk({tag, ".busy"},  BUSY, 0);
    chk({tag, ".wcnt"},  wcnt, NW);
    chk({tag, ".wdata"}, bad, 0);
    chk({tag, ".dwell"}, dwell_gap, DWELL + 1);
    chk({tag, ".proto"}, viol, 0);
  endtask

  task automatic run_test(input string tag, input int m, input int f, input int lo,
                          input int hi, input int fa, input logic [31:0] fm);
    fmode = f; f_addr = fa; f_mask = fm; lat_lo = lo; lat_hi = hi;
    clear_log();
    Mode  = 2'(m);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(tag);
    check_result(tag, m);
  endtask

  initial begin
    int n;
    Reset_n = 1'b0; Start = 1'b0; Mode = 2'd0; INIT_DONE = 1'b0;
    nreq = 0; dwell_pend = 0;
    clear_log();
    repeat (3) @(negedge Clk);
    chk("rst.busy", BUSY, 0);
    chk("rst.req",  {RW_READ, RW_WRITE}, 0);
    chk("rst.addr", DATA_ADDR, 0);
    chk("rst.wdat", DATA_WRITE, 0);
    chk("rst.pf",   {PASS, FAIL, INIT_SEEN}, 0);
    chk("rst.errs", {ERR_COUNT, FIRST_ERR_ADDR, FIRST_ERR_DATA}, 0);

    Reset_n = 1'b1;
    Start   = 1'b1;
    repeat (20) @(negedge Clk);
    chk("preinit.req",  nreq, 0);
    chk("preinit.busy", BUSY, 0);
    chk("preinit.seen", INIT_SEEN, 0);
    Start = 1'b0; INIT_DONE = 1'b1;
    repeat (2) @(negedge Clk);
    chk("init.seen", INIT_SEEN, 1);

    run_test("const",  0, 0, 3, 3, 0, 32'd0);
    run_test("flip",   1, 1, 3, 3, 'h103, 32'd1);
    run_test("zeros",  2, 2, 3, 3, 0, 32'd0);

    // Reset in the middle of the read of index 4.
    fmode = 0; lat_lo = 3; lat_hi = 3;
    clear_log();
    Mode = 2'd0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    n = 0;
    while (!(RW_READ && DATA_ADDR == 25'h104) && n < 6000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 6000) chk("mrst.timeout", 1, 0);
    #1 Reset_n = 1'b0;
    #1;
    chk("mrst.read", RW_READ, 0);
    chk("mrst.busy", BUSY, 0);
    chk("mrst.errs", ERR_COUNT, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    run_test("after_rst", 0, 0, 1, 4, 0, 32'd0);

    // Checkerboard twice with Start held: restart straight from DONE.
    fmode = 0; lat_lo = 1; lat_hi = 10;
    clear_log();
    Mode = 2'd3; Start = 1'b1;
    @(negedge Clk);
    wait_done("b2b1");
    check_result("b2b1", 3);
    clear_log();
    @(negedge Clk);
    chk("b2b.restart", {BUSY, PASS}, 2'b10);
    wait_done("b2b2");
    Start = 1'b0;
    check_result("b2b2", 3);

    for (int r = 0; r < 4; r++) begin
      run_test($sformatf("rnd%0d", r), int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
               1, int'($urandom_range(6, 1)), BASE + int'($urandom_range(NW - 1, 0)),
               32'd1 << $urandom_range(31, 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
